// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared widths, SRAM-wait FSM encoding and match helper
package hazard_stall_unit_pkg;

  localparam int REG_W  = 4;
  localparam int CTRL_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } wait_state_t;

  function automatic logic reg_match(
    input logic [REG_W-1:0] a,
    input logic [REG_W-1:0] b,
    input logic             en
  );
    return en && (a == b);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_sram_wait_fsm.sv
// rtl/hazard_stall_unit_sram_wait_fsm.sv - SRAM access freeze sequencer
module sram_wait_fsm
  import hazard_stall_unit_pkg::*;
#(
  parameter int WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic freeze_all,
  output logic mem_done
);

  localparam logic [3:0] LP_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  wait_state_t r_state;
  wait_state_t w_state_nxt;
  logic [3:0]  r_wcnt;
  logic [3:0]  w_wcnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // The request cycle is itself frozen, so WAIT covers WAIT_CYCLES-1 cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      ST_IDLE: begin
        if (mem_req) begin
          w_wcnt_nxt  = LP_WAIT_LOAD;
          w_state_nxt = (WAIT_CYCLES > 1) ? ST_WAIT : ST_DONE;
        end
      end
      ST_WAIT: begin
        if (r_wcnt > 4'd1) begin
          w_wcnt_nxt = r_wcnt - 4'd1;
        end else begin
          w_wcnt_nxt  = 4'd0;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_wcnt_nxt  = 4'd0;
      end
    endcase
  end

  always_comb begin
    freeze_all = 1'b0;
    mem_done   = 1'b0;
    case (r_state)
      ST_IDLE: freeze_all = mem_req;
      ST_WAIT: freeze_all = 1'b1;
      ST_DONE: mem_done   = 1'b1;
      default: begin
        freeze_all = 1'b0;
        mem_done   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - ID-stage bubble select, pipeline freezes and stall counter
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int WAIT_CYCLES = 5,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             exe_wb_en,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             exe_mem_r_en,
  input  logic             forward_en,
  input  logic             mem_req,
  input  logic             cnt_clr,
  output logic             ctrl_sel,
  output logic             freeze_fd,
  output logic             freeze_all,
  output logic             mem_done,
  output logic [CNT_W-1:0] stall_cnt
);

  logic w_m1, w_m2, w_n1, w_n2;
  logic w_hz;
  logic w_freeze_all;
  logic w_freeze_fd;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_m1 = reg_match(src1, exe_dest, exe_wb_en);
  assign w_m2 = reg_match(src2, exe_dest, exe_wb_en & two_src);
  assign w_n1 = reg_match(src1, mem_dest, mem_wb_en);
  assign w_n2 = reg_match(src2, mem_dest, mem_wb_en & two_src);

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign w_hz = forward_en ? ((w_m1 | w_m2) & exe_mem_r_en)
                           : (w_m1 | w_m2 | w_n1 | w_n2);

  sram_wait_fsm #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_sram_wait_fsm (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .freeze_all(w_freeze_all),
    .mem_done  (mem_done)
  );

  // No bubble while everything is held; the hazard is re-evaluated after release.
  assign w_freeze_fd = w_hz | w_freeze_all;
  assign ctrl_sel    = w_hz & ~w_freeze_all;
  assign freeze_fd   = w_freeze_fd;
  assign freeze_all  = w_freeze_all;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_freeze_fd && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule
